// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads system-ID word 0 and timestamp word 1 over Avalon-MM after reset and flags mismatches.
// Ports: clock/reset (async, active-high); start re-runs the check from DONE;
// avm_* is the read-only master toward the system-ID slave;
// busy/done/id_match/ts_match/timeout_err/fail report status; id_value/ts_value expose the captured words.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID = 32'h1234ABCD,
    parameter logic [31:0] EXPECTED_TS = 32'h521AD205,
    parameter bit          CHECK_TS    = 1'b1,
    parameter int          START_DELAY = 16,
    parameter int          TIMEOUT     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout_err,
    output logic        fail,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    typedef enum logic [2:0] {
        DELAY, RD_ID_CMD, RD_ID_WAIT, RD_TS_CMD, RD_TS_WAIT, CHECK, DONE
    } state_t;
    state_t state_q, state_d;
    logic [15:0] dly_q, dly_d, tmo_q, tmo_d;
    logic [31:0] id_q, id_d, ts_q, ts_d;
    logic id_match_q, id_match_d, ts_match_q, ts_match_d;
    logic timeout_q, timeout_d, fail_q, fail_d;
    logic read_q, read_d, addr_q, addr_d, busy_q, busy_d, done_q, done_d;
    logic last, abort;
    // last: the current cycle is the final one of this transaction's budget
    assign last = tmo_q >= 16'(TIMEOUT - 1);
    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        tmo_d      = tmo_q + 16'd1;
        id_d       = id_q;
        ts_d       = ts_q;
        id_match_d = id_match_q;
        ts_match_d = ts_match_q;
        timeout_d  = timeout_q;
        fail_d     = fail_q;
        abort      = 1'b0;
        case (state_q)
            // reset leaves dly_q at 0, so cycles 0..START_DELAY-1 see 1..START_DELAY
            DELAY: if (dly_q == 16'(START_DELAY)) begin
                state_d = RD_ID_CMD;
                tmo_d   = '0;
            end else dly_d = dly_q + 16'd1;
            RD_ID_CMD: if (last) abort = 1'b1;
                else if (!avm_waitrequest) state_d = RD_ID_WAIT;
            RD_ID_WAIT: if (avm_readdatavalid) begin
                id_d    = avm_readdata;
                state_d = RD_TS_CMD;
                tmo_d   = '0;
            end else if (last) abort = 1'b1;
            RD_TS_CMD: if (last) abort = 1'b1;
                else if (!avm_waitrequest) state_d = RD_TS_WAIT;
            RD_TS_WAIT: if (avm_readdatavalid) begin
                ts_d    = avm_readdata;
                state_d = CHECK;
            end else if (last) abort = 1'b1;
            CHECK: begin
                id_match_d = id_q == EXPECTED_ID;
                ts_match_d = ts_q == EXPECTED_TS;
                fail_d     = (id_q != EXPECTED_ID) | (CHECK_TS & (ts_q != EXPECTED_TS));
                state_d    = DONE;
            end
            // restart enters DELAY with dly=1 so its timing matches the post-reset run
            DONE: if (start) begin
                state_d    = DELAY;
                dly_d      = 16'd1;
                id_d       = '0;
                ts_d       = '0;
                id_match_d = 1'b0;
                ts_match_d = 1'b0;
                timeout_d  = 1'b0;
                fail_d     = 1'b0;
            end
            default: state_d = DELAY;
        endcase
        if (abort) begin
            state_d    = DONE;
            timeout_d  = 1'b1;
            fail_d     = 1'b1;
            id_match_d = 1'b0;
            ts_match_d = 1'b0;
        end
        read_d = (state_d == RD_ID_CMD) | (state_d == RD_TS_CMD);
        addr_d = state_d == RD_TS_CMD;
        busy_d = state_d != DONE;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= DELAY;
            dly_q      <= '0;
            tmo_q      <= '0;
            id_q       <= '0;
            ts_q       <= '0;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
            timeout_q  <= 1'b0;
            fail_q     <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            tmo_q      <= tmo_d;
            id_q       <= id_d;
            ts_q       <= ts_d;
            id_match_q <= id_match_d;
            ts_match_q <= ts_match_d;
            timeout_q  <= timeout_d;
            fail_q     <= fail_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_match    = id_match_q;
    assign ts_match    = ts_match_q;
    assign timeout_err = timeout_q;
    assign fail        = fail_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: directed checks of sysid_boot_checker against a scripted Avalon slave.
module tb_sysid_boot_checker;
    localparam logic [31:0] ID = 32'h1234ABCD;
    localparam logic [31:0] TS = 32'h521AD205;
    logic clk, rst;
    logic [1:0] start, addr, rd_en, wr, rdv, rdv_m, inject;
    logic [1:0] busy, done, idm, tsm, tmo, fail;
    logic [1:0][31:0] rd, rd_m, idv, tsv;
    logic [31:0] id_word [2], ts_word [2], pdata [2];
    int id_stall [2], ts_lat [2], scnt [2], cd [2];
    logic [1:0] ts_drop, drop;
    int cyc, passed, total, fails, b;
    logic [31:0] keep_id, keep_ts;

    sysid_boot_checker u0 (
        .clock(clk), .reset(rst), .start(start[0]), .avm_address(addr[0]), .avm_read(rd_en[0]),
        .avm_waitrequest(wr[0]), .avm_readdata(rd[0]), .avm_readdatavalid(rdv[0]),
        .busy(busy[0]), .done(done[0]), .id_match(idm[0]), .ts_match(tsm[0]),
        .timeout_err(tmo[0]), .fail(fail[0]), .id_value(idv[0]), .ts_value(tsv[0]));
    sysid_boot_checker #(.CHECK_TS(1'b0), .TIMEOUT(8)) u1 (
        .clock(clk), .reset(rst), .start(start[1]), .avm_address(addr[1]), .avm_read(rd_en[1]),
        .avm_waitrequest(wr[1]), .avm_readdata(rd[1]), .avm_readdatavalid(rdv[1]),
        .busy(busy[1]), .done(done[1]), .id_match(idm[1]), .ts_match(tsm[1]),
        .timeout_err(tmo[1]), .fail(fail[1]), .id_value(idv[1]), .ts_value(tsv[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= -1;
        else cyc <= cyc + 1;

    // slave model: id_stall waitrequest cycles on word 0, latency 1 on word 0 and ts_lat on word 1
    always @(negedge clk)
        for (int k = 0; k < 2; k++) begin
            rdv_m[k] = 1'b0;
            if (cd[k] > 0) begin
                cd[k] = cd[k] - 1;
                if (cd[k] == 0 && !drop[k]) begin
                    rdv_m[k] = 1'b1;
                    rd_m[k]  = pdata[k];
                end
            end
            if (rst || !rd_en[k]) begin
                scnt[k] = 0;
                wr[k]   = 1'b0;
            end else if (scnt[k] < (addr[k] ? 0 : id_stall[k])) begin
                scnt[k] = scnt[k] + 1;
                wr[k]   = 1'b1;
            end else begin
                scnt[k]  = 0;
                wr[k]    = 1'b0;
                cd[k]    = addr[k] ? ts_lat[k] : 1;
                pdata[k] = addr[k] ? ts_word[k] : id_word[k];
                drop[k]  = addr[k] & ts_drop[k];
            end
        end
    assign rdv   = rdv_m | inject;
    assign rd[0] = inject[0] ? 32'hDEADBEEF : rd_m[0];
    assign rd[1] = inject[1] ? 32'hDEADBEEF : rd_m[1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int n);
        repeat (n - cyc) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg(input int k, input logic [31:0] iw, input logic [31:0] tw, input int st,
                       input int lat, input logic dr);
        id_word[k]  = iw;
        ts_word[k]  = tw;
        id_stall[k] = st;
        ts_lat[k]   = lat;
        ts_drop[k]  = dr;
    endtask

    task automatic wait_done(input int k, input string tag);
        for (int i = 0; i < 200 && !done[k]; i++) @(negedge clk);
        chk(tag, {31'd0, done[k]}, 32'd1);
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic results(input int k, input string tag, input logic [31:0] iv, input logic [31:0] tv,
                           input logic im, input logic tm, input logic to, input logic fl);
        chk({tag, "_idv"}, idv[k], iv);
        chk({tag, "_tsv"}, tsv[k], tv);
        chk({tag, "_flags"}, {28'd0, idm[k], tsm[k], tmo[k], fail[k]}, {28'd0, im, tm, to, fl});
        chk({tag, "_busy"}, {31'd0, busy[k]}, 32'd0);
    endtask

    initial begin
        passed = 0; total = 0; fails = 0;
        rst = 1'b1; start = '0; inject = '0; drop = '0;
        cd = '{0, 0}; scnt = '{0, 0};
        rdv_m = '0; rd_m = '0; wr = '0;
        cfg(0, ID, TS, 0, 1, 1'b0);
        cfg(1, ID, 32'd0, 0, 1, 1'b0);
        #1;
        chk("rst_outputs", {26'd0, rd_en[0], addr[0], busy[0], done[0], idm[0], tsm[0] | tmo[0] | fail[0]}, 32'b001000);
        chk("rst_values", idv[0] | tsv[0], 32'd0);
        do_reset();
        // nominal timing on u0, timestamp mismatch ignored on u1
        goto(15);
        chk("t15_delay", {30'd0, rd_en[0], busy[0]}, 32'b01);
        goto(16);
        chk("t16_rd_id", {30'd0, rd_en[0], addr[0]}, 32'b10);
        goto(17);
        chk("t17_wait", {31'd0, rd_en[0]}, 32'd0);
        goto(18);
        chk("t18_rd_ts", {30'd0, rd_en[0], addr[0]}, 32'b11);
        goto(20);
        chk("t20_notdone", {31'd0, done[0]}, 32'd0);
        goto(21);
        chk("t21_done", {30'd0, done[0], busy[0]}, 32'b10);
        results(0, "nominal", ID, TS, 1, 1, 0, 0);
        results(1, "ts_nocheck", ID, 32'd0, 1, 0, 0, 0);
        // ID mismatch on u0, timestamp timeout on u1
        cfg(0, 32'h1234ABCE, TS, 0, 1, 1'b0);
        cfg(1, ID, TS, 0, 1, 1'b1);
        do_reset();
        wait_done(0, "idmis_done");
        results(0, "idmis", 32'h1234ABCE, TS, 0, 1, 0, 1);
        wait_done(1, "tmo_done");
        results(1, "tmo", ID, 32'd0, 0, 0, 1, 1);
        chk("tmo_read_low", {31'd0, rd_en[1]}, 32'd0);
        @(negedge clk);
        inject = 2'b11;
        @(negedge clk);
        inject = 2'b00;
        repeat (2) @(negedge clk);
        chk("late_done", {30'd0, done}, 32'b11);
        results(1, "late_rdv_u1", ID, 32'd0, 0, 0, 1, 1);
        results(0, "late_rdv_u0", 32'h1234ABCE, TS, 0, 1, 0, 1);
        // stalled ID read and 2-cycle timestamp latency on u0
        cfg(0, ID, TS, 3, 2, 1'b0);
        cfg(1, ID, TS, 0, 1, 1'b0);
        do_reset();
        for (int t = 16; t <= 19; t++) begin
            goto(t);
            chk($sformatf("stall_hold_%0d", t), {30'd0, rd_en[0], addr[0]}, 32'b10);
        end
        goto(20);
        chk("stall_released", {31'd0, rd_en[0]}, 32'd0);
        goto(24);
        chk("stall_t24", {31'd0, done[0]}, 32'd0);
        goto(25);
        chk("stall_t25", {31'd0, done[0]}, 32'd1);
        results(0, "stall", ID, TS, 1, 1, 0, 0);
        results(1, "pass_nocheck", ID, TS, 1, 1, 0, 0);
        // timestamp mismatch with checking on, start while busy ignored
        cfg(0, ID, 32'd0, 0, 1, 1'b0);
        do_reset();
        goto(4);
        pulse_start(0);
        chk("busy_start_ignored", {30'd0, busy[0], done[0]}, 32'b10);
        goto(16);
        chk("busy_start_t16", {31'd0, rd_en[0]}, 32'd1);
        goto(21);
        chk("busy_start_t21", {31'd0, done[0]}, 32'd1);
        results(0, "tsmis", ID, 32'd0, 1, 0, 0, 1);
        // restart from DONE
        ts_word[0] = TS;
        pulse_start(0);
        b = cyc;
        chk("restart_busy", {30'd0, busy[0], done[0]}, 32'b10);
        chk("restart_clear", {26'd0, idm[0], tsm[0], tmo[0], fail[0], |idv[0], |tsv[0]}, 32'd0);
        goto(b + 15);
        chk("restart_delay", {31'd0, rd_en[0]}, 32'd0);
        goto(b + 16);
        chk("restart_rd_id", {30'd0, rd_en[0], addr[0]}, 32'b10);
        goto(b + 20);
        chk("restart_notdone", {31'd0, done[0]}, 32'd0);
        goto(b + 21);
        chk("restart_done", {31'd0, done[0]}, 32'd1);
        results(0, "restart", ID, TS, 1, 1, 0, 0);
        // reset during the timestamp wait
        pulse_start(0);
        b = cyc;
        goto(b + 19);
        keep_id = idv[0];
        chk("pre_reset_id", keep_id, ID);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {26'd0, rd_en[0], addr[0], busy[0], done[0], idm[0], fail[0]}, 32'b001000);
        chk("midrst_values", idv[0] | tsv[0], 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        goto(21);
        chk("rerun_done", {31'd0, done[0]}, 32'd1);
        results(0, "rerun", ID, TS, 1, 1, 0, 0);
        keep_ts = tsv[0];
        chk("rerun_ts", keep_ts, TS);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
